fetch_queue: RTL and testbench

Dual-issue instruction fetch queue between the fetch unit and the IF/ID pipeline register. Absorbs 1- or 2-instruction fetch packets, presents up to two in-order instructions per cycle to IF/ID, and raises `issue_select` when only slot 0 holds a valid instruction so the IF/ID register clears its issue-1 field. Honors the same `Stall`/`Flush` controls that drive the downstream pipeline register.

---
 rtl/fetch_queue_pkg.sv | 20 ++
 rtl/fetch_queue_mem.sv | 35 +++
 rtl/fetch_queue.sv | 137 +++++++++++++
 tb/tb_fetch_queue.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared constants and helpers for the dual-issue instruction fetch queue.
package fetch_queue_pkg;

    localparam int FQ_INSTR_WIDTH = 32;
    localparam int FQ_ADDR_WIDTH  = 32;
    localparam logic [31:0] FQ_NOP    = 32'h00000013;
    localparam logic [31:0] FQ_PC_INC = 32'd4;

    // Number of entries a packet occupies; encoding 3 is treated as 2.
    function automatic logic [1:0] fq_push_count(input logic [1:0] num);
        logic [1:0] n;
        case (num)
            2'd0:    n = 2'd0;
            2'd1:    n = 2'd1;
            default: n = 2'd2;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: two write ports, two combinational read ports.
module fetch_queue_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we0,
    input  logic [PTR_W-1:0] i_waddr0,
    input  logic [WIDTH-1:0] i_wdata0,
    input  logic             i_we1,
    input  logic [PTR_W-1:0] i_waddr1,
    input  logic [WIDTH-1:0] i_wdata1,
    input  logic [PTR_W-1:0] i_raddr0,
    output logic [WIDTH-1:0] o_rdata0,
    input  logic [PTR_W-1:0] i_raddr1,
    output logic [WIDTH-1:0] o_rdata1
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write ports; the two addresses are always consecutive, so never equal.
    always_ff @(posedge clk) begin
        if (i_we0) begin
            r_mem[i_waddr0] <= i_wdata0;
        end
        if (i_we1) begin
            r_mem[i_waddr1] <= i_wdata1;
        end
    end

    assign o_rdata0 = r_mem[i_raddr0];
    assign o_rdata1 = r_mem[i_raddr1];

endmodule

// File: rtl/fetch_queue.sv
// Dual-issue fetch queue: absorbs 1/2-instruction packets, presents two in-order slots to IF/ID.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int INSTR_WIDTH = FQ_INSTR_WIDTH,
    parameter int ADDR_WIDTH  = FQ_ADDR_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [1:0]               in_num,
    input  logic [ADDR_WIDTH-1:0]    in_pc,
    input  logic [2*INSTR_WIDTH-1:0] in_instr,
    output logic                     in_ready,
    input  logic                     Stall,
    input  logic                     Flush,
    output logic                     out_valid0,
    output logic                     out_valid1,
    output logic [INSTR_WIDTH-1:0]   out_instr0,
    output logic [INSTR_WIDTH-1:0]   out_instr1,
    output logic [ADDR_WIDTH-1:0]    out_pc0,
    output logic [ADDR_WIDTH-1:0]    out_pc1,
    output logic                     issue_select,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_WIDTH + INSTR_WIDTH;

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             w_in_ready;
    logic             w_v0;
    logic             w_v1;
    logic [1:0]       w_push_n;
    logic [1:0]       w_pop_n;
    logic [CNT_W-1:0] w_count_next;
    logic             w_we0;
    logic             w_we1;
    logic [ENT_W-1:0] w_wdata0;
    logic [ENT_W-1:0] w_wdata1;
    logic [ENT_W-1:0] w_rdata0;
    logic [ENT_W-1:0] w_rdata1;

    // Readiness looks only at the registered count; a same-cycle pop never widens it.
    assign w_in_ready = (r_count <= CNT_W'(DEPTH - 2));
    assign w_v0       = (r_count >= CNT_W'(1));
    assign w_v1       = (r_count >= CNT_W'(2));

    // Accepted push size and pop size for this cycle.
    always_comb begin
        w_push_n = 2'd0;
        w_pop_n  = 2'd0;
        if (in_valid && w_in_ready) begin
            w_push_n = fq_push_count(in_num);
        end else begin
            w_push_n = 2'd0;
        end
        if (!Stall) begin
            w_pop_n = 2'({1'b0, w_v0}) + 2'({1'b0, w_v1});
        end else begin
            w_pop_n = 2'd0;
        end
    end

    assign w_count_next = r_count + CNT_W'(w_push_n) - CNT_W'(w_pop_n);

    // Writes are suppressed on flush/reset so a dropped packet leaves no trace.
    assign w_we0    = (w_push_n != 2'd0) && !Flush && !rst;
    assign w_we1    = (w_push_n == 2'd2) && !Flush && !rst;
    assign w_wdata0 = {in_pc, in_instr[INSTR_WIDTH-1:0]};
    assign w_wdata1 = {in_pc + ADDR_WIDTH'(FQ_PC_INC), in_instr[2*INSTR_WIDTH-1:INSTR_WIDTH]};

    // Pointer and occupancy state; reset and flush both empty the queue.
    always_ff @(posedge clk) begin
        if (rst || Flush) begin
            r_head  <= {PTR_W{1'b0}};
            r_tail  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
        end else begin
            r_head  <= r_head + PTR_W'(w_pop_n);
            r_tail  <= r_tail + PTR_W'(w_push_n);
            r_count <= w_count_next;
        end
    end

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk      (clk),
        .i_we0    (w_we0),
        .i_waddr0 (r_tail),
        .i_wdata0 (w_wdata0),
        .i_we1    (w_we1),
        .i_waddr1 (r_tail + PTR_W'(1)),
        .i_wdata1 (w_wdata1),
        .i_raddr0 (r_head),
        .o_rdata0 (w_rdata0),
        .i_raddr1 (r_head + PTR_W'(1)),
        .o_rdata1 (w_rdata1)
    );

    // Slot presentation; empty slots show a NOP at PC 0.
    always_comb begin
        out_instr0 = INSTR_WIDTH'(FQ_NOP);
        out_pc0    = {ADDR_WIDTH{1'b0}};
        out_instr1 = INSTR_WIDTH'(FQ_NOP);
        out_pc1    = {ADDR_WIDTH{1'b0}};
        if (w_v0) begin
            out_instr0 = w_rdata0[INSTR_WIDTH-1:0];
            out_pc0    = w_rdata0[ENT_W-1:INSTR_WIDTH];
        end else begin
            out_instr0 = INSTR_WIDTH'(FQ_NOP);
            out_pc0    = {ADDR_WIDTH{1'b0}};
        end
        if (w_v1) begin
            out_instr1 = w_rdata1[INSTR_WIDTH-1:0];
            out_pc1    = w_rdata1[ENT_W-1:INSTR_WIDTH];
        end else begin
            out_instr1 = INSTR_WIDTH'(FQ_NOP);
            out_pc1    = {ADDR_WIDTH{1'b0}};
        end
    end

    assign in_ready     = w_in_ready;
    assign out_valid0   = w_v0;
    assign out_valid1   = w_v1;
    assign issue_select = w_v0 & ~w_v1;
    assign count        = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: vector table with expected count/ready plus a slot scoreboard.
module tb_fetch_queue;

    localparam int DEPTH = 8;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [1:0]  in_num;
    logic [31:0] in_pc;
    logic [63:0] in_instr;
    logic        in_ready;
    logic        Stall;
    logic        Flush;
    logic        out_valid0, out_valid1;
    logic [31:0] out_instr0, out_instr1, out_pc0, out_pc1;
    logic        issue_select;
    logic [3:0]  count;

    fetch_queue #(.DEPTH(DEPTH), .INSTR_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_num(in_num), .in_pc(in_pc),
        .in_instr(in_instr), .in_ready(in_ready), .Stall(Stall), .Flush(Flush),
        .out_valid0(out_valid0), .out_valid1(out_valid1), .out_instr0(out_instr0),
        .out_instr1(out_instr1), .out_pc0(out_pc0), .out_pc1(out_pc1),
        .issue_select(issue_select), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [1:0]  n;
        logic [31:0] pc;
        logic        st;
        logic        fl;
        logic        rs;
        int          exp_count;
        logic        exp_ready;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    vec_t vecs[$];
    ent_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [31:0] pc);
        return {pc[15:0], 16'hC0DE} ^ 32'h5A000000;
    endfunction

    function automatic void add(input logic v, input logic [1:0] n, input logic [31:0] pc,
                                input logic st, input logic fl, input logic rs,
                                input int ec, input logic er);
        vec_t x;
        x.v = v; x.n = n; x.pc = pc; x.st = st; x.fl = fl; x.rs = rs;
        x.exp_count = ec; x.exp_ready = er;
        vecs.push_back(x);
    endfunction

    // Compare all slot outputs against the scoreboard head.
    task automatic check_slots();
        int sz;
        sz = sb.size();
        chk("count_sb", 64'(count), 64'(sz));
        chk("valid0", 64'(out_valid0), 64'(sz >= 1));
        chk("valid1", 64'(out_valid1), 64'(sz >= 2));
        chk("issue_select", 64'(issue_select), 64'(sz == 1));
        chk("in_ready_sb", 64'(in_ready), 64'((DEPTH - sz) >= 2));
        chk("slot0_pc", 64'(out_pc0), 64'(sz >= 1 ? sb[0].pc : 32'd0));
        chk("slot0_instr", 64'(out_instr0), 64'(sz >= 1 ? sb[0].instr : NOP));
        chk("slot1_pc", 64'(out_pc1), 64'(sz >= 2 ? sb[1].pc : 32'd0));
        chk("slot1_instr", 64'(out_instr1), 64'(sz >= 2 ? sb[1].instr : NOP));
    endtask

    // One clock: check current outputs, drive inputs, update scoreboard, advance.
    task automatic cycle(input vec_t x);
        int   sz;
        int   npop;
        ent_t e;
        check_slots();
        rst = x.rs; Flush = x.fl; Stall = x.st; in_valid = x.v; in_num = x.n; in_pc = x.pc;
        in_instr = {mk_instr(x.pc + 32'd4), mk_instr(x.pc)};
        sz = sb.size();
        if (x.rs || x.fl) begin
            sb.delete();
        end else begin
            npop = x.st ? 0 : (sz >= 2 ? 2 : sz);
            for (int i = 0; i < npop; i++) void'(sb.pop_front());
            if (x.v && ((DEPTH - sz) >= 2) && x.n != 2'd0) begin
                e.pc = x.pc; e.instr = mk_instr(x.pc);
                sb.push_back(e);
                if (x.n != 2'd1) begin
                    e.pc = x.pc + 32'd4; e.instr = mk_instr(x.pc + 32'd4);
                    sb.push_back(e);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t idle;
        rst = 1'b1; Flush = 1'b0; Stall = 1'b0; in_valid = 1'b0; in_num = 2'd0;
        in_pc = 32'd0; in_instr = 64'd0;
        @(posedge clk); @(negedge clk);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_instr0", 64'(out_instr0), 64'(NOP));
        chk("rst_instr1", 64'(out_instr1), 64'(NOP));
        chk("rst_issue", 64'(issue_select), 64'd0);

        //  v     n      pc            st    fl    rs    cnt rdy
        add(1'b0, 2'd0, 32'h000, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        add(1'b1, 2'd2, 32'h100, 1'b1, 1'b0, 1'b0, 2, 1'b1);
        add(1'b0, 2'd0, 32'h000, 1'b1, 1'b0, 1'b0, 2, 1'b1);
        add(1'b0, 2'd0, 32'h000, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        add(1'b1, 2'd1, 32'h200, 1'b1, 1'b0, 1'b0, 1, 1'b1);
        add(1'b0, 2'd0, 32'h000, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        // fill under stall up to the full boundary; tail wraps here
        add(1'b1, 2'd2, 32'h300, 1'b1, 1'b0, 1'b0, 2, 1'b1);
        add(1'b1, 2'd2, 32'h308, 1'b1, 1'b0, 1'b0, 4, 1'b1);
        add(1'b1, 2'd2, 32'h310, 1'b1, 1'b0, 1'b0, 6, 1'b1);
        add(1'b1, 2'd1, 32'h318, 1'b1, 1'b0, 1'b0, 7, 1'b0);
        add(1'b1, 2'd2, 32'h320, 1'b1, 1'b0, 1'b0, 7, 1'b0);
        add(1'b1, 2'd1, 32'h324, 1'b1, 1'b0, 1'b0, 7, 1'b0);
        add(1'b0, 2'd0, 32'h000, 1'b0, 1'b0, 1'b0, 5, 1'b1);
        add(1'b1, 2'd2, 32'h330, 1'b0, 1'b0, 1'b0, 5, 1'b1);
        add(1'b1, 2'd2, 32'h338, 1'b0, 1'b0, 1'b0, 5, 1'b1);
        add(1'b0, 2'd0, 32'h000, 1'b0, 1'b0, 1'b0, 3, 1'b1);
        add(1'b0, 2'd0, 32'h000, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        add(1'b0, 2'd0, 32'h000, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        // push and pop of two at count 4
        add(1'b1, 2'd2, 32'h400, 1'b1, 1'b0, 1'b0, 2, 1'b1);
        add(1'b1, 2'd2, 32'h408, 1'b1, 1'b0, 1'b0, 4, 1'b1);
        add(1'b1, 2'd2, 32'h410, 1'b0, 1'b0, 1'b0, 4, 1'b1);
        add(1'b0, 2'd0, 32'h000, 1'b0, 1'b0, 1'b0, 2, 1'b1);
        add(1'b0, 2'd0, 32'h000, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        // flush with push and stall at count 5
        add(1'b1, 2'd2, 32'h500, 1'b1, 1'b0, 1'b0, 2, 1'b1);
        add(1'b1, 2'd2, 32'h508, 1'b1, 1'b0, 1'b0, 4, 1'b1);
        add(1'b1, 2'd1, 32'h510, 1'b1, 1'b0, 1'b0, 5, 1'b1);
        add(1'b1, 2'd2, 32'h520, 1'b1, 1'b1, 1'b0, 0, 1'b1);
        add(1'b0, 2'd0, 32'h000, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        // reset mid-stream
        add(1'b1, 2'd2, 32'h600, 1'b1, 1'b0, 1'b0, 2, 1'b1);
        add(1'b1, 2'd1, 32'h608, 1'b1, 1'b0, 1'b0, 3, 1'b1);
        add(1'b1, 2'd2, 32'h610, 1'b1, 1'b0, 1'b1, 0, 1'b1);
        add(1'b0, 2'd0, 32'h000, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        // in_num=3 pushes two, in_num=0 pushes nothing
        add(1'b1, 2'd3, 32'h700, 1'b1, 1'b0, 1'b0, 2, 1'b1);
        add(1'b1, 2'd0, 32'h740, 1'b1, 1'b0, 1'b0, 2, 1'b1);
        add(1'b0, 2'd0, 32'h000, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        // sustained two-per-cycle throughput
        add(1'b1, 2'd2, 32'h800, 1'b0, 1'b0, 1'b0, 2, 1'b1);
        add(1'b1, 2'd2, 32'h808, 1'b0, 1'b0, 1'b0, 2, 1'b1);
        add(1'b1, 2'd2, 32'h810, 1'b0, 1'b0, 1'b0, 2, 1'b1);
        add(1'b0, 2'd0, 32'h000, 1'b0, 1'b0, 1'b0, 0, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i]);
            chk($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].exp_count));
            chk($sformatf("vec%0d_ready", i), 64'(in_ready), 64'(vecs[i].exp_ready));
        end

        // Hand sequence: two-instruction packet under stall shows consecutive PCs.
        idle = vecs[0];
        idle.st = 1'b1;
        idle.v = 1'b1; idle.n = 2'd2; idle.pc = 32'h900;
        cycle(idle);
        chk("seq_pc0", 64'(out_pc0), 64'h900);
        chk("seq_pc1", 64'(out_pc1), 64'h904);
        chk("seq_issue2", 64'(issue_select), 64'd0);
        idle.v = 1'b0; idle.st = 1'b0;
        cycle(idle);
        chk("seq_drain", 64'(count), 64'd0);

        // Hand sequence: single instruction leaves slot 1 as NOP with issue_select set.
        idle.v = 1'b1; idle.n = 2'd1; idle.pc = 32'hA00; idle.st = 1'b1;
        cycle(idle);
        chk("seq1_valid1", 64'(out_valid1), 64'd0);
        chk("seq1_issue", 64'(issue_select), 64'd1);
        chk("seq1_instr1", 64'(out_instr1), 64'(NOP));
        chk("seq1_instr0", 64'(out_instr0), 64'(mk_instr(32'hA00)));
        idle.v = 1'b0; idle.st = 1'b0;
        cycle(idle);
        check_slots();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
